dmem_ctrl: RTL and testbench

- Access controller in front of the word-addressed data memory (`dmem`). That memory has a combinational read, a word-only synchronous write, and no sub-word support.
- Arbitrates between the core load/store port and a word-only debug port.
- Sequences byte/halfword loads (extract plus sign/zero extension) and sub-word stores (read-modify-write).
- Reports misaligned, out-of-range and illegal-size accesses without touching memory.

---
 rtl/dmem_ctrl_pkg.sv | 41 ++++
 rtl/dmem_ctrl_lane.sv | 61 ++++++
 rtl/dmem_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg
//   Shared encodings for the data-memory access controller:
//   size codes, error codes, FSM state enum, arbitration port ids
//   and small helper functions.
//   Optional feature macro used by dmem_ctrl: DMEM_CTRL_STATS_EN.
package dmem_ctrl_pkg;

  // Access size encodings (c_size)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Error codes (c_err)
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_MIS  = 2'b01;
  localparam logic [1:0] ERR_OOR  = 2'b10;
  localparam logic [1:0] ERR_SIZE = 2'b11;

  // Port ids used for ownership and last_grant
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_MERGE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

  // 16-bit counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane.sv
// dmem_lane
//   Combinational byte/half lane logic for the data-memory controller.
//   Ports:
//     word_i      : word read from memory (load extract source)
//     base_i      : word captured for read-modify-write (merge base)
//     size_i      : access size (SZ_B / SZ_H / SZ_W)
//     off_i       : byte offset within the word (addr[1:0])
//     unsigned_i  : 1 = zero-extend loads, 0 = sign-extend
//     wdata_i     : right-aligned store data
//     load_o      : extracted and extended load value
//     merge_o     : base_i with the addressed lane replaced by wdata_i
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] base_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (off_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_B:    load_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      SZ_H:    load_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      default: load_o = word_i;
    endcase

    merge_o = base_i;
    case (size_i)
      SZ_B: begin
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_H: begin
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
//   Access controller in front of a word-addressed data memory with
//   combinational read and word-only synchronous write. Arbitrates a core
//   load/store port against a word-only debug port, sequences sub-word
//   loads (extract + extend) and stores (read-modify-write), and reports
//   illegal-size / misaligned / out-of-range accesses without touching memory.
//
//   Handshake: a port holds req with stable fields; ready pulses for the one
//   IDLE cycle in which that port is granted (the operation is latched at
//   that edge); done pulses for one cycle later with rdata/err valid.
//
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     c_*                   : core port (req/we/size/unsigned/addr/wdata in,
//                             ready/done/rdata/err out)
//     d_*                   : debug port (word only; d_err = out of range)
//     mem_a/mem_we/mem_wd   : memory address, write enable, write data
//     mem_rd                : combinational memory read data
//     stat_acc/rmw/err      : saturating counters, only when
//                             DMEM_CTRL_STATS_EN is defined
//
//   State is visible on the internal signal state_q (state_e).
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [1:0]        c_size,
  input  logic              c_unsigned,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ready,
  output logic              c_done,
  output logic [31:0]       c_rdata,
  output logic [1:0]        c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
`ifdef DMEM_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_acc,
  output logic [15:0]       stat_rmw,
  output logic [15:0]       stat_err
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS * 4);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       c_rdata_q, c_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              grant_c, grant_d;
  logic [1:0]        c_chk_err, d_chk_err;
  logic [31:0]       lane_load, lane_merge;
  logic              st_acc, st_merge, st_resp;

  assign st_acc   = (state_q == ST_ACC);
  assign st_merge = (state_q == ST_MERGE);
  assign st_resp  = (state_q == ST_RESP);

  // Round-robin on ties: the core wins unless it was the last port granted.
  assign grant_c = c_req && (!d_req || (last_grant_q == PORT_DBG));
  assign grant_d = d_req && !grant_c;

  // Ready is combinational but is held low while reset is asserted so an
  // asynchronous reset suppresses it within the same cycle.
  assign c_ready = (state_q == ST_IDLE) && !reset && grant_c;
  assign d_ready = (state_q == ST_IDLE) && !reset && grant_d;

  // Error priority: illegal size, misaligned, out of range.
  always_comb begin
    if (c_size == SZ_X)                       c_chk_err = ERR_SIZE;
    else if (is_misaligned(c_size, c_addr[1:0])) c_chk_err = ERR_MIS;
    else if (c_addr >= ADDR_LIMIT)            c_chk_err = ERR_OOR;
    else                                      c_chk_err = ERR_OK;
  end

  // Limit is a multiple of 4, so comparing the raw address matches the
  // word-aligned comparison.
  assign d_chk_err = (d_addr >= ADDR_LIMIT) ? ERR_OOR : ERR_OK;

  dmem_lane u_lane (
    .word_i     (mem_rd),
    .base_i     (merge_q),
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    merge_d      = merge_q;
    c_rdata_d    = c_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (c_ready) begin
          owner_d      = PORT_CORE;
          last_grant_d = PORT_CORE;
          we_d         = c_we;
          size_d       = c_size;
          uns_d        = c_unsigned;
          addr_d       = c_addr;
          wdata_d      = c_wdata;
          err_d        = c_chk_err;
          state_d      = (c_chk_err == ERR_OK) ? ST_ACC : ST_RESP;
        end else if (d_ready) begin
          owner_d      = PORT_DBG;
          last_grant_d = PORT_DBG;
          we_d         = d_we;
          size_d       = SZ_W;
          uns_d        = 1'b0;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          err_d        = d_chk_err;
          state_d      = (d_chk_err == ERR_OK) ? ST_ACC : ST_RESP;
        end
      end
      ST_ACC: begin
        if (!we_q) begin
          if (owner_q == PORT_CORE) c_rdata_d = lane_load;
          else                      d_rdata_d = mem_rd;
          state_d = ST_RESP;
        end else if (size_q == SZ_W) begin
          state_d = ST_RESP;
        end else begin
          merge_d = mem_rd;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_CORE;
      last_grant_q <= PORT_DBG;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= ERR_OK;
      merge_q      <= '0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      merge_q      <= merge_d;
      c_rdata_q    <= c_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Memory side is decoded from the registered state only; errored accesses
  // never enter ACC/MERGE so they can never write.
  assign mem_a  = (st_acc || st_merge) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_we = (st_acc && we_q && (size_q == SZ_W)) || st_merge;
  assign mem_wd = st_merge ? lane_merge :
                  (st_acc && we_q && (size_q == SZ_W)) ? wdata_q : '0;

  assign c_done  = st_resp && (owner_q == PORT_CORE);
  assign d_done  = st_resp && (owner_q == PORT_DBG);
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign c_err   = c_done ? err_q : ERR_OK;
  assign d_err   = d_done && (err_q == ERR_OOR);

`ifdef DMEM_CTRL_STATS_EN
  logic [15:0] stat_acc_q, stat_acc_d;
  logic [15:0] stat_rmw_q, stat_rmw_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_rmw_d = stat_rmw_q;
    stat_err_d = stat_err_q;
    if (st_resp) begin
      if (err_q != ERR_OK) begin
        stat_err_d = sat_inc16(stat_err_q);
      end else begin
        stat_acc_d = sat_inc16(stat_acc_q);
        if (we_q && (size_q != SZ_W)) stat_rmw_d = sat_inc16(stat_rmw_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_acc_q <= '0;
      stat_rmw_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_rmw_q <= stat_rmw_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_acc = stat_acc_q;
  assign stat_rmw = stat_rmw_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl
//   Directed bench for dmem_ctrl with a behavioural 64-word memory.
//   Stats checks are included when DMEM_CTRL_STATS_EN is defined.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        c_req, c_we, c_unsigned, c_ready, c_done;
  logic [1:0]  c_size, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_ready, d_done, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
`ifdef DMEM_CTRL_STATS_EN
  logic [15:0] stat_acc, stat_rmw, stat_err;
`endif

  dmem_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready), .c_done(c_done),
    .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_CTRL_STATS_EN
    , .stat_acc(stat_acc), .stat_rmw(stat_rmw), .stat_err(stat_err)
`endif
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (poke_en)     mem[poke_idx] <= poke_val;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        pend_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx[5:0]; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One access on either port. lat = cycles from accept edge to done;
  // wem[i] = mem_we seen i cycles after the accept edge (0 = accept cycle).
  task automatic do_op(input logic port, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic [1:0] er,
                       output int lat, output logic [7:0] wem);
    int w;
    rd = '0; er = '0; lat = 0; wem = '0; w = 0;
    @(negedge clk);
    if (port == PORT_CORE) begin
      c_req = 1'b1; c_we = we; c_size = sz; c_unsigned = uns; c_addr = addr; c_wdata = wd;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end
    #1;
    while (!(port ? d_ready : c_ready) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (!(port ? d_ready : c_ready)) begin
      check("accept_timeout", 32'd0, 32'd1);
      c_req = 1'b0; d_req = 1'b0;
      return;
    end
    wem[0] = mem_we;
    @(posedge clk);
    @(negedge clk);
    c_req = 1'b0; d_req = 1'b0;
    lat = 1;
    #1;
    while (!(port ? d_done : c_done) && lat < 7) begin
      wem[lat[2:0]] = mem_we;
      @(negedge clk); #1; lat++;
    end
    if (!(port ? d_done : c_done)) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    wem[lat[2:0]] = mem_we;
    rd = port ? d_rdata : c_rdata;
    er = port ? {1'b0, d_err} : c_err;
  endtask

  logic [31:0] rd;
  logic [1:0]  er;
  int          lat;
  logic [7:0]  wem;
  int          acc, dn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    c_req = 0; c_we = 0; c_size = SZ_W; c_unsigned = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    #1;
    // ---- reset state ----
    check("rst_c_ready", {31'b0, c_ready}, 0);
    check("rst_c_done",  {31'b0, c_done}, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_c_err",   {30'b0, c_err}, 0);
    check("rst_d_done",  {31'b0, d_done}, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_we",  {31'b0, mem_we}, 0);
    check("rst_mem_a",   mem_a, 0);
    check("rst_state",   {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    repeat (3) @(negedge clk);
    reset = 1'b0;

    poke(0, 32'hAABBCCDD);
    poke(1, 32'h11223344);
    poke(3, 32'h00008001);
    poke(63, 32'h0F0F0F0F);

    // ---- byte store read-modify-write ----
    do_op(PORT_CORE, 1, SZ_B, 0, 32'h5, 32'hFFFFFFAB, rd, er, lat, wem);
    check("sb_lat", lat, 3);
    check("sb_err", {30'b0, er}, 0);
    check("sb_we_pattern", {24'b0, wem}, 32'h04);
    check("sb_mem", mem[1], 32'h1122AB44);

    // ---- load extract / extension ----
    poke(1, 32'h80FF0000);
    do_op(PORT_CORE, 0, SZ_B, 0, 32'h6, 0, rd, er, lat, wem);
    check("lb_signed", rd, 32'hFFFFFFFF);
    check("lb_lat", lat, 2);
    do_op(PORT_CORE, 0, SZ_B, 1, 32'h6, 0, rd, er, lat, wem);
    check("lbu", rd, 32'h000000FF);
    do_op(PORT_CORE, 0, SZ_H, 0, 32'h6, 0, rd, er, lat, wem);
    check("lh_signed", rd, 32'hFFFF80FF);
    do_op(PORT_CORE, 0, SZ_B, 1, 32'h7, 0, rd, er, lat, wem);
    check("lbu_lane3", rd, 32'h00000080);
    do_op(PORT_CORE, 0, SZ_H, 1, 32'hC, 0, rd, er, lat, wem);
    check("lhu_lane0", rd, 32'h00008001);
    do_op(PORT_CORE, 0, SZ_H, 0, 32'hC, 0, rd, er, lat, wem);
    check("lh_lane0", rd, 32'hFFFF8001);

    // ---- half store, word store and load back ----
    do_op(PORT_CORE, 1, SZ_H, 0, 32'h2, 32'h00001234, rd, er, lat, wem);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[0], 32'h1234CCDD);
    do_op(PORT_CORE, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, wem);
    check("sw_lat", lat, 2);
    check("sw_we_pattern", {24'b0, wem}, 32'h02);
    do_op(PORT_CORE, 0, SZ_W, 0, 32'h10, 0, rd, er, lat, wem);
    check("lw", rd, 32'hDEADBEEF);

    // ---- address boundary ----
    do_op(PORT_CORE, 0, SZ_B, 1, 32'hFF, 0, rd, er, lat, wem);
    check("lbu_last_byte", rd, 32'h0000000F);
    check("lbu_last_err", {30'b0, er}, 0);
    do_op(PORT_CORE, 0, SZ_W, 0, 32'h100, 0, rd, er, lat, wem);
    check("lw_oor_err", {30'b0, er}, {30'b0, ERR_OOR});

    // ---- errors ----
    do_op(PORT_CORE, 0, SZ_H, 0, 32'h3, 0, rd, er, lat, wem);
    check("mis_err", {30'b0, er}, {30'b0, ERR_MIS});
    check("mis_lat", lat, 1);
    check("mis_no_we", {24'b0, wem}, 0);
    @(negedge clk); #1;
    check("err_zero_idle", {30'b0, c_err}, 0);
    do_op(PORT_CORE, 1, SZ_W, 0, 32'h100, 32'h12345678, rd, er, lat, wem);
    check("sw_oor_err", {30'b0, er}, {30'b0, ERR_OOR});
    check("sw_oor_no_we", {24'b0, wem}, 0);
    do_op(PORT_CORE, 0, SZ_X, 0, 32'h0, 0, rd, er, lat, wem);
    check("size_err", {30'b0, er}, {30'b0, ERR_SIZE});
    do_op(PORT_CORE, 1, SZ_W, 0, 32'h102, 32'h1, rd, er, lat, wem);
    check("prio_mis_over_oor", {30'b0, er}, {30'b0, ERR_MIS});
    do_op(PORT_CORE, 1, SZ_X, 0, 32'h103, 32'h1, rd, er, lat, wem);
    check("prio_size_first", {30'b0, er}, {30'b0, ERR_SIZE});

    // ---- debug port ----
    do_op(PORT_DBG, 1, SZ_W, 0, 32'h1F, 32'hCAFEF00D, rd, er, lat, wem);
    check("dw_lat", lat, 2);
    check("dw_mem", mem[7], 32'hCAFEF00D);
    do_op(PORT_DBG, 0, SZ_W, 0, 32'h1C, 0, rd, er, lat, wem);
    check("dr_data", rd, 32'hCAFEF00D);
    check("dr_err", {30'b0, er}, 0);
    do_op(PORT_DBG, 0, SZ_W, 0, 32'h100, 0, rd, er, lat, wem);
    check("dr_oor_err", {30'b0, er}, 1);
    check("dr_oor_lat", lat, 1);

    // ---- arbitration: both ports held ----
    exp_q = {PORT_CORE, PORT_DBG, PORT_CORE, PORT_DBG};
    @(negedge clk);
    c_we = 0; c_size = SZ_W; c_unsigned = 0; c_addr = 32'h10;
    d_we = 0; d_addr = 32'h1C;
    c_req = 1; d_req = 1;
    acc = 0; dn = 0;
    for (int cyc = 0; cyc < 60 && dn < 4; cyc++) begin
      if (acc == 4) begin c_req = 0; d_req = 0; end
      #1;
      if (c_ready || d_ready) begin
        check("arb_grant", {31'b0, d_ready}, exp_q.pop_front());
        pend_q.push_back(d_ready);
        acc++;
      end
      if (c_done || d_done) begin
        check("arb_single_done", {31'b0, c_done & d_done}, 0);
        if (pend_q.size() == 0) check("arb_spurious_done", 32'd1, 32'd0);
        else check("arb_done_port", {31'b0, d_done}, {31'b0, pend_q.pop_front()});
        if (c_done) check("arb_c_rdata", c_rdata, 32'hDEADBEEF);
        if (d_done) check("arb_d_rdata", d_rdata, 32'hCAFEF00D);
        dn++;
      end
      @(negedge clk);
    end
    c_req = 0; d_req = 0;
    check("arb_done_count", dn, 4);

    // ---- reset during MERGE ----
    poke(2, 32'h55667788);
    @(negedge clk);
    c_req = 1; c_we = 1; c_size = SZ_H; c_unsigned = 0; c_addr = 32'h8; c_wdata = 32'h9999;
    #1;
    check("rm_ready", {31'b0, c_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    c_req = 0; #1;
    check("rm_acc_no_we", {31'b0, mem_we}, 0);
    @(negedge clk); #1;
    check("rm_merge_we", {31'b0, mem_we}, 1);
    c_req = 1; c_we = 0; c_size = SZ_W;
    reset = 1'b1;
    #1;
    check("rm_we_drop", {31'b0, mem_we}, 0);
    check("rm_done_drop", {31'b0, c_done}, 0);
    check("rm_ready_drop", {31'b0, c_ready}, 0);
    check("rm_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    @(negedge clk);
    c_req = 0;
    @(negedge clk);
    reset = 1'b0;
    check("rm_mem_kept", mem[2], 32'h55667788);
    do_op(PORT_CORE, 0, SZ_W, 0, 32'h8, 0, rd, er, lat, wem);
    check("rm_after_data", rd, 32'h55667788);
    check("rm_after_lat", lat, 2);

    // ---- counters: load above, one byte store, one misaligned ----
    do_op(PORT_CORE, 1, SZ_B, 0, 32'h9, 32'h77, rd, er, lat, wem);
    check("sb2_mem", mem[2], 32'h55667788 & 32'hFFFF00FF | 32'h00007700);
    do_op(PORT_CORE, 0, SZ_W, 0, 32'h9, 0, rd, er, lat, wem);
    check("lw_mis_err", {30'b0, er}, {30'b0, ERR_MIS});
`ifdef DMEM_CTRL_STATS_EN
    @(negedge clk);
    check("stat_acc", {16'b0, stat_acc}, 2);
    check("stat_rmw", {16'b0, stat_rmw}, 1);
    check("stat_err", {16'b0, stat_err}, 1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
